mdac_seq_ctrl: RTL and testbench

Multi-cycle shift-add multiply-accumulate sequencer for the mdac datapath. It accepts two unsigned WIDTH-bit operands under a start handshake. It runs exactly WIDTH add/shift iterations over internal registers, then presents a 2*WIDTH-bit product or accumulated result with a one-cycle done pulse. It is the control layer that sequences the edge-triggered register bank built from the team's dff cells into a usable arithmetic unit.

---
 rtl/mdac_pkg.sv | 14 +
 rtl/mdac_datapath.sv | 36 +++
 rtl/mdac_seq_ctrl.sv | 86 ++++++++
 tb/tb_mdac_seq_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mdac_pkg.sv
// Shared types and limits for the mdac shift-add multiply-accumulate sequencer.
package mdac_pkg;

  localparam int MDAC_WIDTH_MIN = 2;
  localparam int MDAC_WIDTH_MAX = 16;

  // The unused code 2'b11 is treated as IDLE by the controller.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mdac_datapath.sv
// Shift-add register bank (mcand, mplier, p): load seeds it, each step does one add/shift iteration.
// No handshake of its own; it advances only when the controller strobes it.
module mdac_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] p_init,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Sum is truncated to 2*WIDTH bits, so accumulate overflow wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      p      <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      p      <= p_init;
    end else if (step) begin
      if (mplier[0]) p <= p + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mdac_seq_ctrl.sv
// Multiply/MAC sequencer: done pulses WIDTH+1 cycles after the start edge, product updates one edge later.
// start is honoured only in IDLE; requests while busy are dropped, not queued.
module mdac_seq_ctrl
  import mdac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               acc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic               load;
  logic               step;
  logic               commit;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_init;

  assign p_init = acc ? product : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      RUN: begin
        step      = 1'b1;
        state_nxt = (cnt == LAST) ? DONE : RUN;
      end
      DONE: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      product <= '0;
    end else begin
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
      if (commit) product <= p;
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  mdac_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .a      (a),
    .b      (b),
    .p_init (p_init),
    .p      (p)
  );

endmodule

// File: tb/tb_mdac_seq_ctrl.sv
// Directed bench for mdac_seq_ctrl at WIDTH=8 and WIDTH=4 with hand-computed results.
module tb_mdac_seq_ctrl;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          acc = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  logic           start4 = 1'b0;
  logic           acc4 = 1'b0;
  logic [W4-1:0]  a4 = '0;
  logic [W4-1:0]  b4 = '0;
  logic           busy4;
  logic           done4;
  logic [2*W4-1:0] product4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdac_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .acc(acc), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  mdac_seq_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .acc(acc4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation on the WIDTH=8 unit; hold keeps start asserted through RUN and DONE.
  task automatic run_op(input string tag, input logic acc_i, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_i, input logic hold,
                        input logic [2*W-1:0] prev, input logic [2*W-1:0] exp);
    int n_done;
    int first_done;
    @(negedge clk);
    start = 1'b1; acc = acc_i; a = a_i; b = b_i;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    acc = 1'b0; a = '0; b = '0;
    n_done = 0;
    first_done = 0;
    for (int n = 1; n <= W + 2; n++) begin
      @(negedge clk);
      if (n == W + 2) start = 1'b0;
      if (n == 1) check({tag, "_busy_rise"}, busy, 1);
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = n;
      end
      if (n == W + 1) check({tag, "_prod_during_done"}, product, prev);
    end
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_done_cycle"}, first_done, W + 1);
    check({tag, "_product"}, product, exp);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_product", product, 0);
    check("rst_product4", product4, 0);
    reset = 1'b1;

    run_op("mul_3x5",   1'b0, 8'd3,   8'd5,   1'b0, 16'd0,      16'd15);
    run_op("mac_2x3",   1'b1, 8'd2,   8'd3,   1'b0, 16'd15,     16'd21);
    run_op("mul_ffxff", 1'b0, 8'd255, 8'd255, 1'b0, 16'd21,     16'hFE01);
    run_op("mac_wrap",  1'b1, 8'd255, 8'd255, 1'b0, 16'hFE01,   16'hFC02);
    run_op("b0_hold",   1'b0, 8'd200, 8'd0,   1'b1, 16'hFC02,   16'd0);
    run_op("mul_7x7",   1'b0, 8'd7,   8'd7,   1'b0, 16'd0,      16'd49);

    // Asynchronous reset in the middle of a clock interval during RUN.
    @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_product", product, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_product", product, 0);
    run_op("after_rst_7x6", 1'b0, 8'd7, 8'd6, 1'b0, 16'd0, 16'd42);

    // WIDTH=4 instance.
    begin
      int n_done;
      int first_done;
      @(negedge clk);
      start4 = 1'b1; acc4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
      @(posedge clk);
      #1 start4 = 1'b0;
      n_done = 0;
      first_done = 0;
      for (int n = 1; n <= W4 + 2; n++) begin
        @(negedge clk);
        if (n == 1) check("w4_busy_rise", busy4, 1);
        if (done4) begin
          n_done++;
          if (first_done == 0) first_done = n;
        end
        if (n == W4 + 1) check("w4_prod_during_done", product4, 0);
      end
      check("w4_done_count", n_done, 1);
      check("w4_done_cycle", first_done, W4 + 1);
      check("w4_product", product4, 8'hE1);
      check("w4_busy_idle", busy4, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
